// File: rtl/clk_gen_multi.sv
// clk_gen_multi: N_CH independent phase-accumulator clock dividers with
// glitch-free per-channel halt, period-boundary frequency updates, wrap
// ticks and a global phase-align sync.
// Ports:
//   clk_i       system clock, all logic on rising edge
//   rst_i       synchronous active-high reset
//   freq_sel_i  per-channel select, channel k at [k*SEL_WIDTH +: SEL_WIDTH]
//   halt_i      per-channel halt request (level)
//   sync_i      one-cycle strobe, zeroes every accumulator
//   clk_o       generated clocks (accumulator MSB)
//   tick_o      one-cycle pulse on accumulator wrap
//   halted_o    channel frozen
module clk_gen_multi #(
    parameter int N_CH      = 4,
    parameter int SEL_WIDTH = 8,
    parameter int ACC_WIDTH = SEL_WIDTH + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CH*SEL_WIDTH-1:0] freq_sel_i,
    input  logic [N_CH-1:0]           halt_i,
    input  logic                      sync_i,
    output logic [N_CH-1:0]           clk_o,
    output logic [N_CH-1:0]           tick_o,
    output logic [N_CH-1:0]           halted_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    // An increment above half the accumulator range could leave the MSB
    // set right after a wrap, which would break the glitch-free halt.
    if (ACC_WIDTH < SEL_WIDTH + 1) begin : g_bad_width
        $error("clk_gen_multi: ACC_WIDTH must be >= SEL_WIDTH+1");
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [ACC_WIDTH-1:0] acc;
        logic [ACC_WIDTH-1:0] acc_nxt;
        logic [SEL_WIDTH:0]   inc;
        logic [SEL_WIDTH:0]   inc_nxt;
        logic [SEL_WIDTH:0]   inc_new;
        logic [ACC_WIDTH:0]   sum;
        state_t               st;
        state_t               st_nxt;
        logic                 tick;
        logic                 tick_nxt;
        logic                 wrap;
        logic                 msb;

        assign inc_new = {1'b0, freq_sel_i[k*SEL_WIDTH +: SEL_WIDTH]}
                       + (SEL_WIDTH+1)'(1);
        assign sum     = {1'b0, acc} + (ACC_WIDTH+1)'(inc);
        assign wrap    = sum[ACC_WIDTH];
        assign msb     = acc[ACC_WIDTH-1];

        always_comb begin
            acc_nxt  = acc;
            inc_nxt  = inc;
            st_nxt   = st;
            tick_nxt = 1'b0;
            if (sync_i) begin
                acc_nxt = '0;
                inc_nxt = inc_new;
                st_nxt  = halt_i[k] ? HALT : RUN;
            end else begin
                unique case (st)
                    HALT: begin
                        // keep the shadow tracking sel while frozen
                        inc_nxt = inc_new;
                        if (!halt_i[k]) st_nxt = RUN;
                    end
                    RUN, DRAIN: begin
                        if (st == RUN && halt_i[k] && !msb) begin
                            // low phase: freeze immediately
                            st_nxt = HALT;
                        end else begin
                            acc_nxt  = sum[ACC_WIDTH-1:0];
                            tick_nxt = wrap;
                            if (wrap) inc_nxt = inc_new;
                            // high phase: finish it, stop on the wrap
                            if (halt_i[k]) st_nxt = wrap ? HALT : DRAIN;
                            else           st_nxt = RUN;
                        end
                    end
                    default: st_nxt = RUN;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                acc  <= '0;
                inc  <= inc_new;
                st   <= RUN;
                tick <= 1'b0;
            end else begin
                acc  <= acc_nxt;
                inc  <= inc_nxt;
                st   <= st_nxt;
                tick <= tick_nxt;
            end
        end

        assign clk_o[k]    = msb;
        assign tick_o[k]   = tick;
        assign halted_o[k] = (st == HALT);
    end

endmodule
